// File: rtl/elevator_call_dispatcher_if.sv
// Bundle of button, FSM-handshake and lamp signals between the elevator
// front panel / FSM and the call dispatcher.
interface elevator_call_dispatcher_if;
   logic [3:0] cab_btn;
   logic [2:0] hall_up_btn;
   logic [2:0] hall_dn_btn;
   logic [1:0] Actual_Stage;
   logic       UD_Answer;
   logic       Delay;
   logic       FR_Delay;
   logic [2:0] Solicitud_stage;
   logic [2:0] next_stage;
   logic       OC_Request;
   logic       UD_Request;
   logic [3:0] cab_lamp;
   logic [2:0] up_lamp;
   logic [2:0] dn_lamp;

   modport master (
      output cab_btn, hall_up_btn, hall_dn_btn, Actual_Stage, UD_Answer,
             Delay, FR_Delay, Solicitud_stage,
      input  next_stage, OC_Request, UD_Request, cab_lamp, up_lamp, dn_lamp
   );

   modport slave (
      input  cab_btn, hall_up_btn, hall_dn_btn, Actual_Stage, UD_Answer,
             Delay, FR_Delay, Solicitud_stage,
      output next_stage, OC_Request, UD_Request, cab_lamp, up_lamp, dn_lamp
   );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// Call dispatcher for a 4-floor elevator: latches hall/cabin calls, services
// the floor on arrival (door timing), and selects the next target with a
// direction-preserving SCAN policy, optionally overridden by a locked target.
module elevator_call_dispatcher #(
   parameter int unsigned DOOR_CYCLES = 10
) (
   input logic                        clk,
   input logic                        reset,
   elevator_call_dispatcher_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ARRIVE, S_DOOR} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cab_q, cab_d;
   logic [2:0]  up_q, up_d;          // bit i = floor i
   logic [2:0]  dn_q, dn_d;          // bit i = floor i+1
   logic [1:0]  cur_floor_q, cur_floor_d;
   logic        dir_q, dir_d;
   logic        lock_valid_q, lock_valid_d;
   logic [1:0]  lock_floor_q, lock_floor_d;
   logic [7:0]  door_cnt_q, door_cnt_d;
   logic        delay_q, delay_d;
   logic        fr_q, fr_d;
   logic [2:0]  next_stage_q, next_stage_d;
   logic        oc_q, oc_d;
   logic        ud_q, ud_d;

   // Floor-indexed views of the hall registers and the combined pending set
   logic [3:0]  up4, dn4, pend, cur_oh;
   logic        has_up, has_dn;
   logic [1:0]  up_f, dn_f;
   logic        delay_rise, fr_rise;

   assign up4        = {1'b0, up_q};
   assign dn4        = {dn_q, 1'b0};
   assign pend       = cab_q | up4 | dn4;
   assign cur_oh     = 4'b0001 << cur_floor_q;
   assign delay_rise = bus.Delay & ~delay_q;
   assign fr_rise    = bus.FR_Delay & ~fr_q;

   assign bus.cab_lamp   = cab_q;
   assign bus.up_lamp    = up_q;
   assign bus.dn_lamp    = dn_q;
   assign bus.next_stage = next_stage_q;
   assign bus.OC_Request = oc_q;
   assign bus.UD_Request = ud_q;

   // Find nearest pending floor above and below the current floor
   always_comb begin
      has_up = 1'b0;
      has_dn = 1'b0;
      up_f   = 2'd0;
      dn_f   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i > int'(cur_floor_q) && pend[i]) begin
            has_up = 1'b1;
            up_f   = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i < int'(cur_floor_q) && pend[i]) begin
            has_dn = 1'b1;
            dn_f   = 2'(i);
         end
      end
   end

   // Target selection and direction request for the FSM
   always_comb begin
      next_stage_d = 3'd0;
      ud_d         = ud_q;
      if (lock_valid_q)
         next_stage_d = {1'b0, lock_floor_q} + 3'd1;
      else if (dir_q && has_up)
         next_stage_d = {1'b0, up_f} + 3'd1;
      else if (!dir_q && has_dn)
         next_stage_d = {1'b0, dn_f} + 3'd1;
      else if (has_dn)
         next_stage_d = {1'b0, dn_f} + 3'd1;
      else if (has_up)
         next_stage_d = {1'b0, up_f} + 3'd1;
      else if (pend[cur_floor_q] && state_q != S_DOOR)
         next_stage_d = {1'b0, cur_floor_q} + 3'd1;

      if (next_stage_d != 3'd0) begin
         if (next_stage_d > ({1'b0, cur_floor_q} + 3'd1))
            ud_d = 1'b1;
         else if (next_stage_d < ({1'b0, cur_floor_q} + 3'd1))
            ud_d = 1'b0;
      end
   end

   // Arrival/door sequencing, call latching/clearing and target lock
   always_comb begin
      logic clr_cab, clr_up, clr_dn, lock_clr;
      logic svc_dir, svc_rev, ahead;

      state_d      = state_q;
      cur_floor_d  = cur_floor_q;
      dir_d        = dir_q;
      door_cnt_d   = door_cnt_q;
      oc_d         = oc_q;
      delay_d      = bus.Delay;
      fr_d         = bus.FR_Delay;
      clr_cab      = 1'b0;
      clr_up       = 1'b0;
      clr_dn       = 1'b0;
      lock_clr     = 1'b0;
      ahead        = dir_q ? has_up : has_dn;
      svc_dir      = dir_q ? up4[cur_floor_q] : dn4[cur_floor_q];
      svc_rev      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (delay_rise) begin
               cur_floor_d = bus.Actual_Stage;
               dir_d       = bus.UD_Answer;
               state_d     = S_ARRIVE;
            end
         end
         S_ARRIVE: begin
            // Reverse only at the end of a sweep, when the matching-direction
            // hall call is absent and nothing is left ahead.
            svc_rev = !svc_dir && !ahead &&
                      (dir_q ? dn4[cur_floor_q] : up4[cur_floor_q]);
            if (cab_q[cur_floor_q] || svc_dir || svc_rev) begin
               clr_cab    = 1'b1;
               clr_up     = dir_q ^ svc_rev;
               clr_dn     = ~(dir_q ^ svc_rev);
               dir_d      = dir_q ^ svc_rev;
               lock_clr   = 1'b1;
               door_cnt_d = 8'(DOOR_CYCLES - 1);
               oc_d       = 1'b1;
               state_d    = S_DOOR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DOOR: begin
            // Presses for this floor in the travel direction are absorbed
            clr_cab = 1'b1;
            clr_up  = dir_q;
            clr_dn  = ~dir_q;
            if (door_cnt_q == 8'd0) begin
               oc_d    = 1'b0;
               state_d = S_IDLE;
            end else begin
               door_cnt_d = door_cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cab_d = (cab_q | bus.cab_btn)     & ~(clr_cab ? cur_oh      : 4'b0000);
      up_d  = (up_q  | bus.hall_up_btn) & ~(clr_up  ? cur_oh[2:0] : 3'b000);
      dn_d  = (dn_q  | bus.hall_dn_btn) & ~(clr_dn  ? cur_oh[3:1] : 3'b000);

      lock_valid_d = lock_valid_q;
      lock_floor_d = lock_floor_q;
      if (fr_rise && bus.Solicitud_stage != 3'd0 && bus.Solicitud_stage <= 3'd4) begin
         lock_valid_d = 1'b1;
         lock_floor_d = 2'(bus.Solicitud_stage - 3'd1);
      end
      // Servicing the locked floor releases the lock, even if set this cycle
      if (lock_clr && lock_floor_d == cur_floor_q)
         lock_valid_d = 1'b0;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cab_q        <= '0;
         up_q         <= '0;
         dn_q         <= '0;
         cur_floor_q  <= 2'd0;
         dir_q        <= 1'b1;
         lock_valid_q <= 1'b0;
         lock_floor_q <= 2'd0;
         door_cnt_q   <= 8'd0;
         delay_q      <= 1'b0;
         fr_q         <= 1'b0;
         next_stage_q <= 3'd0;
         oc_q         <= 1'b0;
         ud_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         cab_q        <= cab_d;
         up_q         <= up_d;
         dn_q         <= dn_d;
         cur_floor_q  <= cur_floor_d;
         dir_q        <= dir_d;
         lock_valid_q <= lock_valid_d;
         lock_floor_q <= lock_floor_d;
         door_cnt_q   <= door_cnt_d;
         delay_q      <= delay_d;
         fr_q         <= fr_d;
         next_stage_q <= next_stage_d;
         oc_q         <= oc_d;
         ud_q         <= ud_d;
      end
   end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher with hand-computed expectations.
module tb_elevator_call_dispatcher;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   oc_cnt;

   elevator_call_dispatcher_if bus();

   elevator_call_dispatcher #(.DOOR_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   // Delay pulse, then one more edge so the ARRIVE decision has been registered
   task automatic arrive(input logic [1:0] fl, input logic up);
      bus.Actual_Stage = fl;
      bus.UD_Answer    = up;
      bus.Delay        = 1'b1;
      step(1);
      bus.Delay        = 1'b0;
      step(1);
   endtask

   task automatic wait_door();
      for (int i = 0; i < 40 && bus.OC_Request; i++) step(1);
      chk("door_end", 8'(bus.OC_Request), 8'd0);
   endtask

   task automatic press(input logic [3:0] c, input logic [2:0] u, input logic [2:0] d);
      bus.cab_btn     = c;
      bus.hall_up_btn = u;
      bus.hall_dn_btn = d;
      step(1);
      bus.cab_btn     = 4'd0;
      bus.hall_up_btn = 3'd0;
      bus.hall_dn_btn = 3'd0;
   endtask

   initial begin
      bus.cab_btn = 4'd0;  bus.hall_up_btn = 3'd0; bus.hall_dn_btn = 3'd0;
      bus.Actual_Stage = 2'd0; bus.UD_Answer = 1'b0; bus.Delay = 1'b0;
      bus.FR_Delay = 1'b0; bus.Solicitud_stage = 3'd0;

      // Reset then idle
      do_reset();
      chk("rst_cab",  8'(bus.cab_lamp),   8'd0);
      chk("rst_up",   8'(bus.up_lamp),    8'd0);
      chk("rst_dn",   8'(bus.dn_lamp),    8'd0);
      chk("rst_next", 8'(bus.next_stage), 8'd0);
      chk("rst_oc",   8'(bus.OC_Request), 8'd0);
      chk("rst_ud",   8'(bus.UD_Request), 8'd1);

      // Cabin call to floor 3 and arrival with full door window
      press(4'b1000, 3'd0, 3'd0);
      chk("cab_lamp1", 8'(bus.cab_lamp), 8'd8);
      step(1);
      chk("cab_next", 8'(bus.next_stage), 8'd4);
      chk("cab_ud",   8'(bus.UD_Request), 8'd1);
      bus.Actual_Stage = 2'd3; bus.UD_Answer = 1'b1; bus.Delay = 1'b1;
      step(1);
      bus.Delay = 1'b0;
      chk("arr_oc_pre", 8'(bus.OC_Request), 8'd0);
      step(1);
      chk("arr_oc_on",  8'(bus.OC_Request), 8'd1);
      chk("arr_cab_clr", 8'(bus.cab_lamp), 8'd0);
      oc_cnt = 1;
      for (int i = 0; i < 19; i++) begin
         step(1);
         if (bus.OC_Request) oc_cnt++;
      end
      chk("door_len",  8'(oc_cnt), 8'd10);
      chk("arr_oc_off", 8'(bus.OC_Request), 8'd0);
      chk("arr_next0", 8'(bus.next_stage), 8'd0);

      // SCAN order: at floor 1 going up, cab[0] and up[2] pending
      arrive(2'd1, 1'b1);
      chk("scan_nosvc", 8'(bus.OC_Request), 8'd0);
      press(4'b0001, 3'b100, 3'd0);
      chk("scan_cab", 8'(bus.cab_lamp), 8'd1);
      chk("scan_up",  8'(bus.up_lamp),  8'd4);
      step(1);
      chk("scan_next3", 8'(bus.next_stage), 8'd3);
      chk("scan_ud1",   8'(bus.UD_Request), 8'd1);
      arrive(2'd2, 1'b1);
      chk("scan_oc",     8'(bus.OC_Request), 8'd1);
      chk("scan_up_clr", 8'(bus.up_lamp),    8'd0);
      chk("scan_cab_kept", 8'(bus.cab_lamp), 8'd1);
      step(1);
      chk("scan_next1", 8'(bus.next_stage), 8'd1);
      chk("scan_ud0",   8'(bus.UD_Request), 8'd0);
      wait_door();

      // Reversal at the end of an up sweep: only dn at floor 2 pending
      do_reset();
      press(4'd0, 3'd0, 3'b010);
      chk("rev_dn_lamp", 8'(bus.dn_lamp), 8'd2);
      step(1);
      chk("rev_next", 8'(bus.next_stage), 8'd3);
      arrive(2'd2, 1'b1);
      chk("rev_oc",     8'(bus.OC_Request), 8'd1);
      chk("rev_dn_clr", 8'(bus.dn_lamp),    8'd0);
      wait_door();
      // Now heading down: floor 0 is chosen ahead of floor 3
      press(4'b1001, 3'd0, 3'd0);
      step(1);
      chk("rev_dir_next", 8'(bus.next_stage), 8'd1);
      chk("rev_dir_ud",   8'(bus.UD_Request), 8'd0);

      // Lock: invalid floor ignored, valid floor overrides SCAN
      do_reset();
      press(4'b1000, 3'd0, 3'd0);
      step(1);
      bus.FR_Delay = 1'b1; bus.Solicitud_stage = 3'd5;
      step(1);
      bus.FR_Delay = 1'b0;
      step(1);
      chk("lock_ignore", 8'(bus.next_stage), 8'd4);
      bus.FR_Delay = 1'b1; bus.Solicitud_stage = 3'd2;
      step(1);
      bus.FR_Delay = 1'b0;
      step(1);
      chk("lock_next2", 8'(bus.next_stage), 8'd2);
      chk("lock_ud",    8'(bus.UD_Request), 8'd1);
      press(4'b0010, 3'd0, 3'd0);
      step(1);
      chk("lock_hold", 8'(bus.next_stage), 8'd2);
      chk("lock_cab",  8'(bus.cab_lamp),   8'd10);
      arrive(2'd1, 1'b1);
      step(1);
      chk("lock_rel_next", 8'(bus.next_stage), 8'd4);
      chk("lock_door",     8'(bus.OC_Request), 8'd1);
      chk("lock_cab_clr",  8'(bus.cab_lamp),   8'd8);

      // Presses for the current floor during DOOR are absorbed
      press(4'b0010, 3'b010, 3'd0);
      chk("door_cab_abs", 8'(bus.cab_lamp),   8'd8);
      chk("door_up_abs",  8'(bus.up_lamp),    8'd0);
      chk("door_still",   8'(bus.OC_Request), 8'd1);

      // Reset mid-door
      reset = 1'b1;
      step(1);
      chk("mid_rst_oc",  8'(bus.OC_Request), 8'd0);
      chk("mid_rst_cab", 8'(bus.cab_lamp),   8'd0);
      chk("mid_rst_nx",  8'(bus.next_stage), 8'd0);
      reset = 1'b0;
      step(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/elevator_call_dispatcher.md
# elevator_call_dispatcher

Upstream request stage for the 4-floor elevator controller. Latches hall and cabin call buttons, picks the next target floor with a direction-preserving (SCAN) policy, and drives `next_stage`, `OC_Request` and `UD_Request` into the elevator FSM. It consumes the FSM's arrival and forwarding strobes to clear serviced calls and to lock in a committed target.

## Interface
- `DOOR_CYCLES`, default 10: cycles `OC_Request` is held high per door service. Legal range is 1..255.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `cab_btn` input 4: cabin buttons, bit i = floor i. Level-sampled.
- `hall_up_btn` input 3: hall up calls, bit i = floor i (floors 0..2).
- `hall_dn_btn` input 3: hall down calls, bit i = floor i+1 (floors 1..3).
- `Actual_Stage` input 2: current floor index 0..3, from the FSM.
- `UD_Answer` input 1: FSM travel direction, 1 = up, 0 = down.
- `Delay` input 1: FSM arrival strobe. Rising edge = car has arrived at `Actual_Stage`.
- `FR_Delay` input 1: FSM forward strobe. Rising edge = FSM has accepted `Solicitud_stage`.
- `Solicitud_stage` input 3: floor echoed by the FSM with `FR_Delay`.
- `next_stage` output 3: target floor encoded as index+1 (1..4). 0 = nothing pending.
- `OC_Request` output 1: door open request.
- `UD_Request` output 1: requested direction, 1 = up.
- `cab_lamp` output 4: pending cabin calls, same bit mapping as `cab_btn`.
- `up_lamp` output 3: pending up calls, same mapping as `hall_up_btn`.
- `dn_lamp` output 3: pending down calls, same mapping as `hall_dn_btn`.

## Operation
- **Pending registers** `cab[3:0]`, `up[2:0]`, `dn[3:1]`, plus `cur_floor[1:0]`, `dir`, `lock_valid`, `lock_floor[1:0]`, `door_cnt[7:0]`.
- **Lamps** equal the pending registers directly.
- **Button latching:** any button high at a clock edge sets its pending bit. Buttons do not clear bits.
- **Edge detection:** `Delay` and `FR_Delay` are registered. A rising edge is current high AND previous low.
- **State IDLE**
  - On a `Delay` rising edge: `cur_floor <= Actual_Stage`, `dir <= UD_Answer`, go to ARRIVE.
  - Otherwise stay in IDLE.
- **State ARRIVE** (one cycle). The floor is serviced if any of these holds:
  - `cab[cur_floor]` is set;
  - `dir=1` and `up[cur_floor]` is set;
  - `dir=0` and `dn[cur_floor]` is set;
  - no pending call exists ahead in `dir`, and the opposite hall call at `cur_floor` is set. In this case `dir` flips.
- **If serviced:**
  - Clear the serviced bits.
  - Clear `lock_valid` if `lock_floor == cur_floor`.
  - Load `door_cnt <= DOOR_CYCLES-1`, assert `OC_Request`, go to DOOR.
- **If not serviced:** go to IDLE.
- **State DOOR:** `OC_Request=1`. Each cycle, `door_cnt` decrements. When it is 0, deassert `OC_Request` on the next edge and return to IDLE.
- **Button during DOOR:** a press for `cur_floor` with a matching direction (or cabin) is absorbed. The clear wins and the bit stays 0.
- **Target selection** (registered, every cycle, all states):
  - If `lock_valid`: `next_stage = lock_floor+1`.
  - Else, nearest pending floor strictly ahead of `cur_floor` in `dir`, counting any call type.
  - Else, nearest pending floor in the opposite direction.
  - Else, a pending call at `cur_floor` itself, when not in DOOR.
  - Else 0.
- **Direction output:** `UD_Request = 1` if the target is above `cur_floor`, 0 if below. It holds its previous value when the target equals `cur_floor` or is 0.
- **Lock:** on an `FR_Delay` rising edge with `Solicitud_stage` in 1..4, set `lock_valid` and `lock_floor = Solicitud_stage-1`. A `Solicitud_stage` of 0 or above 4 is ignored.
- **Reset values:**
  - all pending bits and lamps 0;
  - `cur_floor` 0, `dir` 1;
  - `lock_valid` 0;
  - state IDLE;
  - `next_stage` 0, `OC_Request` 0, `UD_Request` 1;
  - edge registers 0.
- **Reset mid-door:** `OC_Request` drops on the reset edge and all calls are lost.

## Timing
- **Button to lamp:** 1 cycle. Button to `next_stage`: 2 cycles (latch, then select register).
- **Arrival:** `Delay` rise sampled at edge N; ARRIVE at N; `OC_Request` high from edge N+1 for exactly `DOOR_CYCLES` cycles.
- **Lock:** `FR_Delay` rise at edge N, lock set at N, `next_stage` reflects it at N+1.
- **Simultaneous `Delay` and `FR_Delay` edges:** both take effect. If the lock targets the arrival floor and that floor is serviced, the ARRIVE-cycle clear wins.
- **Held strobe:** a `Delay` held high produces one arrival only. A new arrival needs a low cycle.
- **`Delay` rise during ARRIVE or DOOR:** ignored, but the edge register still updates.

## Test plan
- **Reset then idle:** after `reset`, all lamps 0, `next_stage`=0, `OC_Request`=0, `UD_Request`=1.
- **Cabin call and arrival:** `cab_btn`=4'b1000 for 1 cycle with `cur_floor` 0.
  - `cab_lamp`=1000 after 1 cycle, `next_stage`=4 and `UD_Request`=1 after 2 cycles.
  - Then pulse `Delay` with `Actual_Stage`=3, `UD_Answer`=1: `OC_Request` high exactly 10 cycles, `cab_lamp`=0, `next_stage`=0.
- **SCAN order:** at floor 1 going up, pending `cab[0]` and `up[2]` gives `next_stage`=3. After servicing floor 2, `next_stage`=1 and `UD_Request`=0.
- **Direction reversal at end:** arrival at floor 2 going up, only `dn[2]` pending. Door opens, `dn_lamp`[1] clears, internal `dir` becomes 0.
- **Lock:** pending `cab[3]`, then `FR_Delay` with `Solicitud_stage`=2, then `cab[1]`... press. `next_stage` stays 2 until arrival at floor 1, then becomes 4.
- **Press during door / reset mid-door:**
  - Pressing `cab_btn`[cur_floor] during DOOR leaves the lamp 0.
  - Asserting `reset` mid-DOOR gives `OC_Request`=0 on the next edge and all lamps 0.
